hdlc_tx_channel: RTL

HDLC_TX_CHANNEL -- requirements
Module: hdlc_tx_channel

---
 rtl/hdlc_tx_pkg.sv | 31 +++
 rtl/hdlc_tx_fcs.sv | 26 ++
 rtl/hdlc_tx_channel.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/hdlc_tx_pkg.sv
// Shared types and constants for the HDLC transmit channel.
package hdlc_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START_FLAG,
      DATA,
      FCS,
      END_FLAG,
      ABORT
   } txState_t;

   localparam int unsigned BYTE_W      = 8;
   localparam int unsigned CRC_W       = 16;
   localparam int unsigned STUFF_LIMIT = 5;
   localparam int unsigned ABORT_ONES  = 7;

   localparam logic [BYTE_W-1:0] FLAG_DEFAULT     = 8'h7E;
   localparam logic [CRC_W-1:0]  CRC_POLY_DEFAULT = 16'h1021;
   localparam logic [CRC_W-1:0]  CRC_INIT_DEFAULT = 16'h0000;

   // One serial step of a non-reflected CRC; feeding the register MSB-first afterwards leaves zero.
   function automatic logic [CRC_W-1:0] crcStep(input logic [CRC_W-1:0] crc,
                                                input logic             bitIn,
                                                input logic [CRC_W-1:0] poly);
      logic fb;
      fb = crc[CRC_W-1] ^ bitIn;
      return {crc[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
   endfunction

endpackage

// File: rtl/hdlc_tx_fcs.sv
// Serial CRC-16 generator for the frame check sequence.
module hdlc_tx_fcs
   import hdlc_tx_pkg::*;
#(
   parameter logic [CRC_W-1:0] CRC_POLY = CRC_POLY_DEFAULT,
   parameter logic [CRC_W-1:0] CRC_INIT = CRC_INIT_DEFAULT
)(
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Init,
   input  logic             Enable,
   input  logic             BitIn,
   output logic [CRC_W-1:0] Crc
);

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         Crc <= CRC_INIT;
      end else if (Init) begin
         Crc <= CRC_INIT;
      end else if (Enable) begin
         Crc <= crcStep(Crc, BitIn, CRC_POLY);
      end
   end

endmodule

// File: rtl/hdlc_tx_channel.sv
// HDLC transmit channel: flags, LSB-first data with zero insertion, optional FCS and abort.
module hdlc_tx_channel
   import hdlc_tx_pkg::*;
#(
   parameter logic [BYTE_W-1:0] FLAG     = FLAG_DEFAULT,
   parameter logic [CRC_W-1:0]  CRC_POLY = CRC_POLY_DEFAULT,
   parameter logic [CRC_W-1:0]  CRC_INIT = CRC_INIT_DEFAULT
)(
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Tx_ValidFrame,
   input  logic              Tx_DataAvail,
   input  logic [BYTE_W-1:0] Tx_Data,
   input  logic              Tx_FCSen,
   input  logic              Tx_AbortFrame,
   output logic              Tx,
   output logic              Tx_RdBuff,
   output logic              Tx_NewByte,
   output logic              Tx_Done,
   output logic              Tx_AbortedTrans
);

   localparam logic [3:0] READ_BIT     = 4'd6;
   localparam logic [3:0] LAST_BIT     = 4'd7;
   localparam logic [3:0] LAST_FCS_BIT = 4'(CRC_W - 1);
   localparam logic [3:0] ABORT_LAST   = 4'(ABORT_ONES - 1);
   localparam logic [2:0] ONES_LIMIT   = 3'(STUFF_LIMIT);

   txState_t          state;
   logic [3:0]        bitCnt;
   logic [2:0]        onesCnt;
   logic [BYTE_W-1:0] shiftReg;
   logic [BYTE_W-1:0] holdReg;
   logic              holdValid;
   logic              capPend;
   logic              needLoad;
   logic              fcsEnLatched;
   logic              doneArm;
   logic [CRC_W-1:0]  crcReg;

   logic              frameStart;
   logic              abortNow;
   logic              stuffNow;
   logic              byteComing;
   logic              loadNow;
   logic              crcEnable;
   logic [BYTE_W-1:0] nextByte;
   logic [BYTE_W-1:0] curByte;
   logic              dataBit;
   logic              fcsBit;
   txState_t          boundaryState;

   always_comb begin
      frameStart    = (state == IDLE) && Tx_ValidFrame && Tx_DataAvail;
      abortNow      = Tx_AbortFrame &&
                      ((state == START_FLAG) || (state == DATA) || (state == FCS));
      // A residual stuff bit may still be owed when a frame moves into the end flag.
      stuffNow      = ((state == DATA) || (state == FCS) || (state == END_FLAG)) &&
                      (onesCnt == ONES_LIMIT);
      // A read strobe in flight, a capture pending, or a held byte all guarantee another byte.
      byteComing    = Tx_RdBuff || capPend || holdValid;
      loadNow       = (state == DATA) && needLoad && !stuffNow && !Tx_AbortFrame;
      crcEnable     = (state == DATA) && !stuffNow && !Tx_AbortFrame;
      nextByte      = holdValid ? holdReg : Tx_Data;
      curByte       = needLoad ? nextByte : shiftReg;
      dataBit       = curByte[0];
      fcsBit        = crcReg[LAST_FCS_BIT - bitCnt];
      boundaryState = byteComing ? DATA : (fcsEnLatched ? FCS : END_FLAG);
   end

   hdlc_tx_fcs #(
      .CRC_POLY (CRC_POLY),
      .CRC_INIT (CRC_INIT)
   ) u_fcs (
      .Clk    (Clk),
      .Rst    (Rst),
      .Init   (frameStart),
      .Enable (crcEnable),
      .BitIn  (dataBit),
      .Crc    (crcReg)
   );

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state           <= IDLE;
         bitCnt          <= '0;
         onesCnt         <= '0;
         shiftReg        <= '0;
         holdReg         <= '0;
         holdValid       <= 1'b0;
         capPend         <= 1'b0;
         needLoad        <= 1'b0;
         fcsEnLatched    <= 1'b0;
         doneArm         <= 1'b0;
         Tx              <= 1'b1;
         Tx_RdBuff       <= 1'b0;
         Tx_NewByte      <= 1'b0;
         Tx_Done         <= 1'b0;
         Tx_AbortedTrans <= 1'b0;
      end else begin
         Tx_RdBuff       <= 1'b0;
         Tx_NewByte      <= 1'b0;
         Tx_AbortedTrans <= 1'b0;
         Tx_Done         <= doneArm;
         doneArm         <= 1'b0;
         capPend         <= Tx_RdBuff;

         // Buffer data arrives the cycle after the strobe; bypassed when it is loaded directly.
         if (capPend && !loadNow) begin
            holdReg   <= Tx_Data;
            holdValid <= 1'b1;
         end

         if (abortNow) begin
            state           <= ABORT;
            Tx              <= 1'b0;
            Tx_AbortedTrans <= 1'b1;
            Tx_Done         <= 1'b0;
            bitCnt          <= '0;
            holdValid       <= 1'b0;
            capPend         <= 1'b0;
            needLoad        <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  Tx        <= 1'b1;
                  onesCnt   <= '0;
                  holdValid <= 1'b0;
                  needLoad  <= 1'b0;
                  if (frameStart) begin
                     state        <= START_FLAG;
                     bitCnt       <= '0;
                     fcsEnLatched <= Tx_FCSen;
                  end
               end

               START_FLAG: begin
                  Tx     <= FLAG[bitCnt[2:0]];
                  bitCnt <= bitCnt + 4'd1;
                  if ((bitCnt == READ_BIT) && Tx_DataAvail) begin
                     Tx_RdBuff <= 1'b1;
                  end
                  if (bitCnt == LAST_BIT) begin
                     state    <= boundaryState;
                     needLoad <= byteComing;
                     doneArm  <= !byteComing;
                     onesCnt  <= '0;
                     bitCnt   <= '0;
                  end
               end

               DATA: begin
                  if (stuffNow) begin
                     Tx      <= 1'b0;
                     onesCnt <= '0;
                  end else begin
                     Tx       <= dataBit;
                     shiftReg <= {1'b0, curByte[BYTE_W-1:1]};
                     onesCnt  <= dataBit ? onesCnt + 3'd1 : 3'd0;
                     bitCnt   <= bitCnt + 4'd1;
                     if (needLoad) begin
                        Tx_NewByte <= 1'b1;
                        needLoad   <= 1'b0;
                        holdValid  <= 1'b0;
                     end
                     if ((bitCnt == READ_BIT) && Tx_DataAvail) begin
                        Tx_RdBuff <= 1'b1;
                     end
                     if (bitCnt == LAST_BIT) begin
                        state    <= boundaryState;
                        needLoad <= byteComing;
                        doneArm  <= !byteComing;
                        bitCnt   <= '0;
                     end
                  end
               end

               FCS: begin
                  if (stuffNow) begin
                     Tx      <= 1'b0;
                     onesCnt <= '0;
                  end else begin
                     Tx      <= fcsBit;
                     onesCnt <= fcsBit ? onesCnt + 3'd1 : 3'd0;
                     bitCnt  <= bitCnt + 4'd1;
                     if (bitCnt == LAST_FCS_BIT) begin
                        state  <= END_FLAG;
                        bitCnt <= '0;
                     end
                  end
               end

               END_FLAG: begin
                  if (stuffNow) begin
                     Tx      <= 1'b0;
                     onesCnt <= '0;
                  end else begin
                     Tx      <= FLAG[bitCnt[2:0]];
                     onesCnt <= '0;
                     bitCnt  <= bitCnt + 4'd1;
                     if (bitCnt == LAST_BIT) begin
                        state  <= IDLE;
                        bitCnt <= '0;
                     end
                  end
               end

               ABORT: begin
                  Tx        <= 1'b1;
                  holdValid <= 1'b0;
                  capPend   <= 1'b0;
                  needLoad  <= 1'b0;
                  bitCnt    <= bitCnt + 4'd1;
                  if (bitCnt == ABORT_LAST) begin
                     state  <= IDLE;
                     bitCnt <= '0;
                  end
               end

               default: begin
                  state <= IDLE;
                  Tx    <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule
